// File: rtl/soc_system_dsp_threshold_bank.sv
// Multi-channel threshold detector with hysteresis, sticky rise flags, saturating crossing
// counters and a maskable level interrupt, exposed through an Avalon-MM register bank.
module soc_system_dsp_threshold_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              sample_valid,
  input  logic [2:0]        sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  output logic [NUM_CH-1:0] ch_above,
  output logic              irq
);

  logic              w_wr;
  logic [DATA_W-1:0] w_wdata;
  logic [NUM_CH-1:0] w_wbits;

  logic [NUM_CH-1:0] r_ctrl;
  logic [NUM_CH-1:0] r_status;
  logic [NUM_CH-1:0] r_mask;
  logic [DATA_W-1:0] r_hyst;
  logic              r_irq;
  logic [DATA_W-1:0] r_thr   [NUM_CH];
  logic [CNT_W-1:0]  r_cnt   [NUM_CH];
  logic              r_above [NUM_CH];

  logic [NUM_CH-1:0] w_ctrl_d;
  logic [NUM_CH-1:0] w_status_d;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_cnt_clr;
  logic [DATA_W-1:0] w_low   [NUM_CH];

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[DATA_W-1:0];
  assign w_wbits = writedata[NUM_CH-1:0];

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_hit[g]     = sample_valid & r_ctrl[g] & (sample_ch == 3'(g));
      // Falling level saturates at 0, so a channel with THR <= HYST never falls.
      assign w_low[g]     = (r_thr[g] > r_hyst) ? (r_thr[g] - r_hyst) : '0;
      assign w_rise[g]    = w_hit[g] & ~r_above[g] & (sample_data >= r_thr[g]);
      assign w_fall[g]    = w_hit[g] & r_above[g] & (sample_data < w_low[g]);
      assign w_cnt_clr[g] = w_wr & (address == 5'(16 + g));
      assign ch_above[g]  = r_above[g];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_thr[g]   <= '0;
          r_cnt[g]   <= '0;
          r_above[g] <= 1'b0;
        end else begin
          if (w_wr && (address == 5'(8 + g))) begin
            r_thr[g] <= w_wdata;
          end
          if (w_cnt_clr[g]) begin
            r_cnt[g] <= '0;
          end else if (w_rise[g] && (r_cnt[g] != '1)) begin
            r_cnt[g] <= r_cnt[g] + CNT_W'(1);
          end
          if (!r_ctrl[g] || w_fall[g]) begin
            r_above[g] <= 1'b0;
          end else if (w_rise[g]) begin
            r_above[g] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_ctrl_d = r_ctrl;
    if (w_wr) begin
      case (address)
        5'd0:    w_ctrl_d = w_wbits;
        5'd4:    w_ctrl_d = r_ctrl | w_wbits;
        5'd5:    w_ctrl_d = r_ctrl & ~w_wbits;
        default: w_ctrl_d = r_ctrl;
      endcase
    end
  end

  // A rise on the same edge as a W1C keeps the flag set.
  always_comb begin
    w_status_d = r_status;
    if (w_wr && (address == 5'd1)) begin
      w_status_d = r_status & ~w_wbits;
    end
    w_status_d = w_status_d | w_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl   <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_hyst   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ctrl   <= w_ctrl_d;
      r_status <= w_status_d;
      r_irq    <= |(r_status & r_mask);
      if (w_wr && (address == 5'd2)) begin
        r_mask <= w_wbits;
      end
      if (w_wr && (address == 5'd3)) begin
        r_hyst <= w_wdata;
      end
    end
  end

  assign irq = r_irq;

  always_comb begin
    readdata = '0;
    case (address)
      5'd0:    readdata[NUM_CH-1:0] = r_ctrl;
      5'd1:    readdata[NUM_CH-1:0] = r_status;
      5'd2:    readdata[NUM_CH-1:0] = r_mask;
      5'd3:    readdata[DATA_W-1:0] = r_hyst;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == 5'(8 + i)) begin
            readdata[DATA_W-1:0] = r_thr[i];
          end
          if (address == 5'(16 + i)) begin
            readdata[CNT_W-1:0] = r_cnt[i];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_soc_system_dsp_threshold_bank.sv
// Bench for the threshold bank: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the register map and channel rules.
module tb_soc_system_dsp_threshold_bank;

  localparam int unsigned DW   = 32;
  localparam int unsigned NC   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = 15;

  logic          clk;
  logic          reset_n;
  logic [4:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          sample_valid;
  logic [2:0]    sample_ch;
  logic [DW-1:0] sample_data;
  logic [NC-1:0] ch_above;
  logic          irq;

  soc_system_dsp_threshold_bank #(
    .DATA_W(DW),
    .NUM_CH(NC),
    .CNT_W (CW)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .ch_above    (ch_above),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [31:0] m_thr [4];
  logic [31:0] m_hyst;
  logic [3:0]  m_ctrl;
  logic [3:0]  m_status;
  logic [3:0]  m_mask;
  logic [3:0]  m_above;
  logic        m_irq;
  int unsigned m_cnt [4];

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_thr[ch] = '0;
      m_cnt[ch] = 0;
    end
    m_hyst = '0; m_ctrl = '0; m_status = '0; m_mask = '0; m_above = '0; m_irq = 1'b0;
  endtask

  // One clock of the reference behaviour: channel decisions use pre-edge register values.
  task automatic model_step(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                            input bit sv, input logic [2:0] sc, input logic [31:0] sd);
    logic [3:0]  rise;
    logic [31:0] low;
    rise  = '0;
    m_irq = |(m_status & m_mask);
    for (int ch = 0; ch < 4; ch++) begin
      low = (m_thr[ch] > m_hyst) ? m_thr[ch] - m_hyst : 32'd0;
      if (!m_ctrl[ch]) begin
        m_above[ch] = 1'b0;
      end else if (sv && sc == 3'(ch)) begin
        if (!m_above[ch] && sd >= m_thr[ch]) begin
          m_above[ch] = 1'b1;
          rise[ch]    = 1'b1;
        end else if (m_above[ch] && sd < low) begin
          m_above[ch] = 1'b0;
        end
      end
    end
    if (wr && a == 5'd1) m_status = m_status & ~wd[3:0];
    m_status = m_status | rise;
    for (int ch = 0; ch < 4; ch++) begin
      if (wr && a == 5'(16 + ch)) m_cnt[ch] = 0;
      else if (rise[ch] && m_cnt[ch] < CMAX) m_cnt[ch] = m_cnt[ch] + 1;
    end
    if (wr) begin
      case (a)
        5'd0: m_ctrl = wd[3:0];
        5'd2: m_mask = wd[3:0];
        5'd3: m_hyst = wd;
        5'd4: m_ctrl = m_ctrl | wd[3:0];
        5'd5: m_ctrl = m_ctrl & ~wd[3:0];
        5'd8, 5'd9, 5'd10, 5'd11: m_thr[int'(a) - 8] = wd;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      5'd0: r[3:0] = m_ctrl;
      5'd1: r[3:0] = m_status;
      5'd2: r[3:0] = m_mask;
      5'd3: r = m_hyst;
      5'd8, 5'd9, 5'd10, 5'd11:   r = m_thr[int'(a) - 8];
      5'd16, 5'd17, 5'd18, 5'd19: r = 32'(m_cnt[int'(a) - 16]);
      default: ;
    endcase
    return r;
  endfunction

  task automatic cycle(input bit cs, input bit wn, input logic [4:0] a, input logic [31:0] wd,
                       input bit sv, input logic [2:0] sc, input logic [31:0] sd);
    chipselect   = cs;
    write_n      = wn;
    address      = a;
    writedata    = wd;
    sample_valid = sv;
    sample_ch    = sc;
    sample_data  = sd;
    @(posedge clk);
    model_step(cs && !wn, a, wd, sv, sc, sd);
    #1;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    sample_valid = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] wd);
    cycle(1'b1, 1'b0, a, wd, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic smp(input logic [2:0] sc, input logic [31:0] sd);
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b1, sc, sd);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cycle(1'b0, 1'b1, a, 32'd0, 1'b0, 3'd0, 32'd0);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ch_above !== 4'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got above=%0h irq=%0b exp 0 0", ch_above, irq);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_read[%0d] got %0h exp 0", a, d);
      end
    end
  endtask

  task automatic test_basic_regs();
    logic [31:0] d;
    wr_reg(5'd8, 32'd100);
    wr_reg(5'd4, 32'h1);
    rd(5'd0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL ctrl_read got %0h exp 1", d); end
    rd(5'd8, d);
    checks++;
    if (d !== 32'd100) begin errors++; $display("FAIL thr0_read got %0d exp 100", d); end
    rd(5'd4, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL ctrl_set_read got %0h exp 0", d); end
  endtask

  task automatic test_hysteresis();
    logic [31:0] samples [6];
    logic        exp_above [6];
    logic [31:0] d;
    samples   = '{32'd99, 32'd100, 32'd95, 32'd90, 32'd89, 32'd100};
    exp_above = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    wr_reg(5'd3, 32'd10);
    for (int i = 0; i < 6; i++) begin
      smp(3'd0, samples[i]);
      checks++;
      if (ch_above[0] !== exp_above[i] || ch_above !== m_above) begin
        errors++;
        $display("FAIL hyst_seq[%0d] got %0h exp bit0=%0b model=%0h", i, ch_above,
                 exp_above[i], m_above);
      end
    end
    rd(5'd16, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL hyst_cnt0 got %0d exp 2", d); end
    rd(5'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL hyst_status got %0h exp 1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr_reg(5'd2, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_edge got %0b exp 0", irq); end
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_mask got %0b exp 1", irq); end
    smp(3'd0, 32'd50);
    cycle(1'b1, 1'b0, 5'd1, 32'h1, 1'b1, 3'd0, 32'd100);
    rd(5'd1, d);
    checks++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_vs_rise got status=%0h irq=%0b exp 1 1", d, irq);
    end
    wr_reg(5'd1, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_w1c_edge got %0b exp 1", irq); end
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %0b exp 0", irq); end
  endtask

  task automatic test_low_saturation();
    wr_reg(5'd9, 32'd5);
    wr_reg(5'd3, 32'd20);
    wr_reg(5'd4, 32'h2);
    smp(3'd1, 32'd5);
    smp(3'd1, 32'd0);
    checks++;
    if (ch_above[1] !== 1'b1) begin
      errors++; $display("FAIL low_sat_hold got %0b exp 1", ch_above[1]);
    end
    wr_reg(5'd5, 32'h2);
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    checks++;
    if (ch_above[1] !== 1'b0) begin
      errors++; $display("FAIL disable_forces_below got %0b exp 0", ch_above[1]);
    end
  endtask

  task automatic test_cnt_saturation();
    logic [31:0] d;
    wr_reg(5'd10, 32'd1000);
    wr_reg(5'd3, 32'd0);
    wr_reg(5'd4, 32'h4);
    for (int i = 0; i < 20; i++) begin
      smp(3'd2, 32'd1000 + ($urandom % 100));
      smp(3'd2, $urandom % 1000);
    end
    rd(5'd18, d);
    checks++;
    if (d !== 32'd15) begin errors++; $display("FAIL cnt_saturate got %0d exp 15", d); end
    cycle(1'b1, 1'b0, 5'd18, $urandom, 1'b1, 3'd2, 32'd1500);
    checks++;
    if (ch_above[2] !== 1'b1) begin
      errors++; $display("FAIL cnt_clr_rise_above got %0b exp 1", ch_above[2]);
    end
    rd(5'd18, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL cnt_clear_wins got %0d exp 0", d); end
  endtask

  task automatic test_ignored_samples();
    logic [31:0] d;
    logic [3:0]  snap_status;
    int unsigned snap_cnt [4];
    logic        snap_irq;
    wr_reg(5'd2, 32'hF);
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    snap_status = m_status;
    snap_irq    = m_irq;
    for (int ch = 0; ch < 4; ch++) snap_cnt[ch] = m_cnt[ch];
    for (int i = 0; i < 8; i++) smp(3'(4 + ($urandom % 4)), $urandom);
    wr_reg(5'd0, 32'h0);
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 8; i++) smp(3'(i % 4), 32'hFFFF_FFFF);
    checks++;
    if (ch_above !== 4'h0 || irq !== snap_irq) begin
      errors++;
      $display("FAIL ignored_outputs got above=%0h irq=%0b exp 0 %0b", ch_above, irq, snap_irq);
    end
    rd(5'd1, d);
    checks++;
    if (d !== {28'd0, snap_status}) begin
      errors++; $display("FAIL ignored_status got %0h exp %0h", d, snap_status);
    end
    for (int ch = 0; ch < 4; ch++) begin
      rd(5'(16 + ch), d);
      checks++;
      if (d !== 32'(snap_cnt[ch])) begin
        errors++; $display("FAIL ignored_cnt[%0d] got %0d exp %0d", ch, d, snap_cnt[ch]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  alist [18];
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] sd;
    bit          cs;
    bit          wn;
    alist = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
              5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd31};
    wr_reg(5'd0, 32'hF);
    for (int n = 0; n < 800; n++) begin
      a  = alist[$urandom % 18];
      cs = ($urandom % 3) == 0;
      wn = ($urandom % 2) == 0;
      if (a >= 5'd8 && a <= 5'd12) wd = $urandom % 64;
      else if (a == 5'd3)          wd = $urandom % 16;
      else                         wd = $urandom;
      sd = (($urandom % 16) == 0) ? $urandom : $urandom % 80;
      cycle(cs, wn, a, wd, ($urandom % 4) != 0, 3'($urandom % 8), sd);
      checks++;
      if (ch_above !== m_above || irq !== m_irq || readdata !== model_read(a)) begin
        errors++;
        $display("FAIL random[%0d] got above=%0h irq=%0b rd[%0d]=%0h exp %0h %0b %0h", n,
                 ch_above, irq, a, readdata, m_above, m_irq, model_read(a));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr_reg(5'd8, 32'd10);
    wr_reg(5'd0, 32'h1);
    wr_reg(5'd2, 32'h1);
    smp(3'd0, 32'd20);
    cycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    checks++;
    if (ch_above[0] !== 1'b1 || irq !== 1'b1) begin
      errors++; $display("FAIL pre_reset got above=%0h irq=%0b exp bit0=1 1", ch_above, irq);
    end
    address = 5'd0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ch_above !== 4'h0 || irq !== 1'b0 || readdata !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got above=%0h irq=%0b rd=%0h exp 0 0 0", ch_above, irq,
               readdata);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(5'd8, d);
    checks++;
    if (d !== 32'd0 || ch_above !== 4'h0) begin
      errors++; $display("FAIL post_reset got thr0=%0h above=%0h exp 0 0", d, ch_above);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_regs();
    test_hysteresis();
    test_irq();
    test_low_saturation();
    test_cnt_saturation();
    test_ignored_samples();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
